bvshl_inv_search_ctrl: RTL and testbench

//   Sequential solver for the bvshl inverse.
//   - Given shift amount s and target t, finds x with (x << s) == t (logical, zero-fill).
//   - Enumerates candidates through a shared shift-compare datapath.
//   - Returns the smallest solution, or not-found.
//   - Sits beside the combinational Skolem-function blocks as the checked, handshaked

---
 rtl/bvshl_inv_search_ctrl.sv | 137 +++++++++++++
 tb/tb_bvshl_inv_search_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bvshl_inv_search_ctrl.sv
// bvshl inverse solver: finds the smallest x with (x << s) == t.
// Optional single-cycle check path: define BVSHL_INV_FASTPATH_EN.
module bvshl_inv_search_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_found,
  output logic [W:0]   out_tries,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [W:0]   WN = (W+1)'(W);
  localparam logic [W:0]   T1 = (W+1)'(1);
  localparam logic [W-1:0] C1 = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] cand_q, cand_d;
  logic [W-1:0] x_q, x_d;
  logic         found_q, found_d;
  logic [W:0]   tries_q, tries_d;
  logic         rdy_q, vld_q, busy_q;

  logic         s_big;
  logic [W-1:0] probe;
  logic [W-1:0] sh;
  logic         hit;

  // shared shift-compare datapath
  always_comb begin
    s_big = ({1'b0, s_q} >= WN);
`ifdef BVSHL_INV_FASTPATH_EN
    probe = s_big ? '0 : (t_q >> s_q);
`else
    probe = cand_q;
`endif
    sh  = s_big ? '0 : (probe << s_q);
    hit = (sh == t_q);
  end

  // next-state and result capture
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    cand_d  = cand_q;
    x_d     = x_q;
    found_d = found_q;
    tries_d = tries_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_s;
          t_d     = in_t;
          cand_d  = '0;
          tries_d = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        tries_d = tries_q + T1;
`ifdef BVSHL_INV_FASTPATH_EN
        cand_d  = probe;
        x_d     = hit ? probe : '0;
        found_d = hit;
        state_d = DONE;
`else
        if (hit) begin
          x_d     = cand_q;
          found_d = 1'b1;
          state_d = DONE;
        end else if (cand_q == '1) begin
          x_d     = '0;
          found_d = 1'b0;
          state_d = DONE;
        end else begin
          cand_d = cand_q + C1;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      t_q     <= '0;
      cand_q  <= '0;
      x_q     <= '0;
      found_q <= 1'b0;
      tries_q <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      cand_q  <= cand_d;
      x_q     <= x_d;
      found_q <= found_d;
      tries_q <= tries_d;
      rdy_q   <= (state_d == IDLE);
      vld_q   <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_x     = x_q;
  assign out_found = found_q;
  assign out_tries = tries_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bvshl_inv_search_ctrl.sv
// Bench for bvshl_inv_search_ctrl: directed cases, full sweep, random.
// Honours BVSHL_INV_FASTPATH_EN for expected latency and tries.
module tb_bvshl_inv_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_s = '0;
  logic [3:0] in_t = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_x;
  logic       out_found;
  logic [4:0] out_tries;
  logic       busy;

  int total = 0;
  int bad = 0;

  bvshl_inv_search_ctrl #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_t(in_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_found(out_found),
    .out_tries(out_tries), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // brute force: smallest x with (x * 2^s) mod 16 == t
  task automatic model(input int s, input int t,
                       output int x, output int f);
    x = 0;
    f = 0;
    for (int c = 0; c < 16; c++) begin
      if (f == 0 && ((c * (1 << s)) % 16) == t) begin
        x = c;
        f = 1;
      end
    end
  endtask

  task automatic run_req(input int s, input int t, input int hold);
    int ex, ef, et, el, n;
    model(s, t, ex, ef);
`ifdef BVSHL_INV_FASTPATH_EN
    et = 1;
`else
    et = ef ? ex + 1 : 16;
`endif
    el = et;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_s = 4'(s);
    in_t = 4'(t);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, el);
    check("out_x", int'(out_x), ex);
    check("out_found", int'(out_found), ef);
    check("out_tries", int'(out_tries), et);
    check("in_ready_done", int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_s = 4'($urandom);
      in_t = 4'($urandom);
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_x", int'(out_x), ex);
      check("hold_found", int'(out_found), ef);
      check("hold_tries", int'(out_tries), et);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
    check("busy_back", int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_x"}, int'(out_x), 0);
    check({tag, "_out_found"}, int'(out_found), 0);
    check({tag, "_out_tries"}, int'(out_tries), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1, 6, 0);
    run_req(1, 5, 0);
    run_req(5, 0, 0);
    run_req(4, 1, 0);
    run_req(0, 15, 0);
    run_req(1, 6, 3);

    // reset during an unsolvable search
    in_valid = 1'b1;
    in_s = 4'd1;
    in_t = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(2, 12, 0);

    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 16; t++)
        run_req(s, t, 0);

    for (int i = 0; i < 150; i++)
      run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
